// File: rtl/dm1to4_16_buf_pkg.sv
// Shared constants and types for the 1-to-4 buffered demultiplexer.
package dm1to4_16_buf_pkg;
  localparam int LANES     = 4;
  localparam int SEL_W     = 2;
  localparam int WIDTH_DEF = 16;

  typedef logic [SEL_W-1:0]     lane_idx_t;
  typedef logic [WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/dm1to4_16_buf_if.sv
// Input stream, per-lane output streams and status of the demultiplexer.
interface dm1to4_16_buf_if
  import dm1to4_16_buf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic             in_bcast;
  logic [LANES-1:0] out_valid;
  logic [LANES-1:0] out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [LANES-1:0] lane_full;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           lane_full, xfer_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           lane_full, xfer_cnt
  );
endinterface

// File: rtl/dm1to4_16_buf_lane_fifo.sv
// Per-lane synchronous FIFO; head holds the last popped word while empty.
module dm_lane_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic [AW:0]      occ_nxt;
  logic             full_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign valid     = (occ != '0);
  assign full      = full_q;
  assign do_push   = push && !full_q;
  assign do_pop    = pop && valid;
  assign head_data = valid ? mem[rd_ptr] : last_q;
  assign occ_nxt   = occ + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      full_q <= 1'b0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      // Remember the departing head so the output holds it once empty.
      if (do_pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ    <= occ_nxt;
      full_q <= (occ_nxt == (AW+1)'(DEPTH));
    end
  end
endmodule

// File: rtl/dm1to4_16_buf.sv
// 1-to-4 buffered demultiplexer with broadcast and an accepted-transfer counter.
module dm1to4_16_buf
  import dm1to4_16_buf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  dm1to4_16_buf_if.slave    bus
);
  lane_idx_t        sel;
  logic             accept;
  logic             in_ready;
  logic [LANES-1:0] push;
  logic [LANES-1:0] valid;
  logic [LANES-1:0] full;
  logic [WIDTH-1:0] head [LANES];
  logic [CNT_W-1:0] cnt;

  assign sel = bus.in_sel;
  // Readiness looks only at registered full flags, never at out_ready.
  assign in_ready = bus.in_bcast ? (full == '0) : !full[sel];
  assign accept   = bus.in_valid && in_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign push[k] = accept && (bus.in_bcast || (sel == lane_idx_t'(k)));

    dm_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[k]),
      .push_data (bus.in_data),
      .pop       (bus.out_ready[k]),
      .head_data (head[k]),
      .valid     (valid[k]),
      .full      (full[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (accept) cnt <= cnt + 1'b1;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid;
  assign bus.lane_full = full;
  assign bus.out_data0 = head[0];
  assign bus.out_data1 = head[1];
  assign bus.out_data2 = head[2];
  assign bus.out_data3 = head[3];
  assign bus.xfer_cnt  = cnt;
endmodule

// File: tb/tb_dm1to4_16_buf.sv
// Randomized and directed bench for dm1to4_16_buf against a queue-based lane model.
module tb_dm1to4_16_buf;
  import dm1to4_16_buf_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm1to4_16_buf_if #(.WIDTH(16), .CNT_W(16)) bus();

  dm1to4_16_buf #(.WIDTH(16), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  word_t       mq [4][$];
  word_t       mlast [4];
  logic [15:0] mcnt;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    if (bus.in_bcast) begin
      for (int k = 0; k < 4; k++) if (mq[k].size() >= DEPTH) return 1'b0;
      return 1'b1;
    end
    return mq[bus.in_sel].size() < DEPTH;
  endfunction

  function automatic word_t dut_data(int k);
    case (k)
      0: return bus.out_data0;
      1: return bus.out_data1;
      2: return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  // Reference: each lane is a queue; pops first, then accepted pushes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        mlast[k] = '0;
      end
      mcnt = '0;
    end else begin
      logic rdy;
      rdy = m_ready();
      for (int k = 0; k < 4; k++)
        if (mq[k].size() > 0 && bus.out_ready[k]) mlast[k] = mq[k].pop_front();
      if (bus.in_valid && rdy) begin
        mcnt = mcnt + 16'd1;
        for (int k = 0; k < 4; k++)
          if (bus.in_bcast || bus.in_sel == 2'(k)) mq[k].push_back(bus.in_data);
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] ev, ef;
    for (int k = 0; k < 4; k++) begin
      ev[k] = mq[k].size() != 0;
      ef[k] = mq[k].size() == DEPTH;
      check($sformatf("lane%0d_data", k), 32'(dut_data(k)),
            32'(ev[k] ? mq[k][0] : mlast[k]));
    end
    check("out_valid", 32'(bus.out_valid), 32'(ev));
    check("lane_full", 32'(bus.lane_full), 32'(ef));
    check("in_ready",  32'(bus.in_ready),  32'(m_ready()));
    check("xfer_cnt",  32'(bus.xfer_cnt),  32'(mcnt));
  end

  task automatic step(bit v, bit [1:0] s, bit b, logic [15:0] d, bit [3:0] ordy);
    @(negedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_bcast  = b;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_bcast  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_xfer_cnt",  32'(bus.xfer_cnt),  32'd0);
    check("rst_data0",     32'(bus.out_data0), 32'd0);
    #1 rst_n = 1'b1;

    // Unicast to each lane, all consumers ready.
    for (int k = 0; k < 4; k++) begin
      step(1, 2'(k), 0, 16'(k + 1), 4'hF);
      check("uni_data",  32'(dut_data(k)), 32'(k + 1));
      check("uni_valid", 32'(bus.out_valid), 32'(1 << k));
    end
    step(0, 0, 0, 0, 4'hF);
    check("uni_cnt",   32'(bus.xfer_cnt),  32'd4);
    check("uni_drain", 32'(bus.out_valid), 32'd0);

    // Backpressure on lane 2.
    step(1, 2, 0, 16'hAAAA, 4'hB);
    step(1, 2, 0, 16'hBBBB, 4'hB);
    step(0, 2, 0, 16'h0000, 4'hB);
    check("bp_full",   32'(bus.lane_full[2]), 32'd1);
    check("bp_ready2", 32'(bus.in_ready),     32'd0);
    bus.in_sel = 2'd0;
    #1 check("bp_ready0", 32'(bus.in_ready), 32'd1);
    check("bp_head0", 32'(bus.out_data2), 32'hAAAA);
    step(0, 0, 0, 0, 4'hF);
    check("bp_head1", 32'(bus.out_data2), 32'hBBBB);
    step(0, 0, 0, 0, 4'hF);
    check("bp_empty", 32'(bus.out_valid[2]), 32'd0);

    // Broadcast, then lane 1 blocks further broadcasts.
    step(1, 0, 1, 16'h1234, 4'b1101);
    check("bc_valid", 32'(bus.out_valid), 32'hF);
    for (int k = 0; k < 4; k++) check("bc_data", 32'(dut_data(k)), 32'h1234);
    check("bc_cnt", 32'(bus.xfer_cnt), 32'd7);
    step(1, 1, 0, 16'h5555, 4'b1101);
    check("bc_l1full", 32'(bus.lane_full), 32'b0010);
    step(0, 0, 1, 0, 4'b1101);
    check("bc_blocked", 32'(bus.in_ready), 32'd0);
    step(0, 0, 1, 0, 4'hF);
    check("bc_unblock", 32'(bus.in_ready), 32'd1);
    step(0, 0, 0, 0, 4'hF);

    // Simultaneous push and pop on lane 3 across pointer wrap.
    step(1, 3, 0, 16'h0011, 4'b0111);
    check("pp_head0", 32'(bus.out_data3), 32'h0011);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      d = 16'h0022 + 16'(i * 16'h0011);
      step(1, 3, 0, d, 4'hF);
      check("pp_head",  32'(bus.out_data3),    32'(d));
      check("pp_valid", 32'(bus.out_valid[3]), 32'd1);
      check("pp_full",  32'(bus.lane_full[3]), 32'd0);
    end
    step(0, 0, 0, 0, 4'hF);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom));
    repeat (4) step(0, 0, 0, 0, 4'hF);

    // Counter wrap.
    guard = 0;
    while (mcnt != 16'hFFFF && guard < 70000) begin
      step(1, 2'($urandom_range(0, 3)), 0, 16'($urandom), 4'hF);
      guard++;
    end
    check("wrap_reach", 32'(bus.xfer_cnt), 32'hFFFF);
    step(1, 0, 0, 16'h7777, 4'hF);
    check("wrap_zero", 32'(bus.xfer_cnt), 32'h0000);
    step(0, 0, 0, 0, 4'hF);

    // Asynchronous reset with lanes 0 and 3 full.
    step(1, 0, 0, 16'h0A0A, 4'h0);
    step(1, 3, 0, 16'h3A3A, 4'h0);
    step(1, 0, 0, 16'h0B0B, 4'h0);
    step(1, 3, 0, 16'h3B3B, 4'h0);
    check("mid_full", 32'(bus.lane_full), 32'b1001);
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(bus.out_valid), 32'd0);
    check("mid_full0", 32'(bus.lane_full), 32'd0);
    check("mid_cnt",   32'(bus.xfer_cnt),  32'd0);
    check("mid_ready", 32'(bus.in_ready),  32'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dm1to4_16_buf.md
Name: dm1to4_16_buf

Overview:
- 1-to-4 buffered demultiplexer: steers a 16-bit input stream to one of four output lanes chosen by a 2-bit select, or to all four lanes in broadcast mode.
- Counterpart of the 4-to-1 16-bit mux on the distribution side of the datapath.
- Each lane has a small FIFO and an independent valid/ready handshake, so a stalled consumer blocks only traffic addressed to it.
- A free-running counter reports accepted transfers.

Parameters:
- WIDTH, 16, data width of input and each lane.
- DEPTH, 2, entries per lane FIFO; power of two, >= 2.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word will be accepted this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination lane 0..3; ignored when in_bcast=1.
- in_bcast  input  1  write the word to all four lanes.
- out_valid  output  4  per-lane head-of-FIFO valid.
- out_ready  input  4  per-lane consumer ready.
- out_data0 .. out_data3  output  WIDTH each  per-lane head-of-FIFO data.
- lane_full  output  4  per-lane FIFO full flag.
- xfer_cnt  output  CNT_W  count of accepted input transfers.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All FIFO pointers and occupancies go to 0 and all storage is cleared to 0.
  - out_valid=4'b0, out_data*=0, lane_full=0, xfer_cnt=0, in_ready=1.
  - Any words in flight are discarded. Deassertion takes effect from the next rising edge.
- Input acceptance:
  - Unicast: in_ready = !lane_full[in_sel].
  - Broadcast: in_ready = (lane_full == 4'b0).
  - in_ready depends only on the registered full flags and on in_sel/in_bcast. It never depends on out_ready; there is no full-and-pop pass-through.
  - A transfer occurs on an edge where in_valid && in_ready. Unicast pushes in_data into lane in_sel only. Broadcast pushes the same word into all four lanes on the same edge.
  - in_valid=0: no push. in_sel/in_data are don't-care and must not change state.
- Output side, lane k:
  - out_valid[k] = occupancy_k != 0. out_data_k = the oldest entry.
  - A pop occurs on an edge where out_valid[k] && out_ready[k].
  - While out_valid[k]=0, out_data_k holds its last value (0 after reset).
- Latency: a word pushed at edge N appears on out_valid/out_data at edge N, i.e. it is visible during cycle N+1. There is no combinational bypass from in_data to out_data.
- Simultaneous push and pop on one lane:
  - Allowed whenever the lane is not full before the edge. Occupancy is unchanged.
  - Data order is strictly FIFO.
- Full/empty flags:
  - lane_full[k] = occupancy_k == DEPTH, registered.
  - Pop on empty is impossible because out_valid gates it.
  - Push on full is impossible because in_ready gates it.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- xfer_cnt:
  - Increments by 1 per accepted input transfer. A broadcast counts as 1.
  - Wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- No reordering across lanes. Lanes are fully independent apart from the broadcast full check.

Decomposition:
- Shared package holds:
  - LANES=4 and SEL_W=2 constants.
  - Lane-index typedef (2-bit).
  - Data-word typedef sized by WIDTH.
- Natural sub-module: dm_lane_fifo, a synchronous FIFO of WIDTH x DEPTH.
  - Ports: clk, rst_n, push, push_data, pop, head_data, valid, full.
  - Instantiated four times.
- Top level holds only the select decode, the in_ready logic and xfer_cnt.

Test Plan:
- Reset then unicast: send 0x0001 to lane 0, 0x0002 to lane 1, 0x0003 to lane 2 and 0x0004 to lane 3 with out_ready=4'hF.
  - Each out_data_k shows k+1 exactly one cycle after its push; out_valid pulses one cycle per lane.
  - xfer_cnt=4.
- Backpressure: out_ready[2]=0, push 0xAAAA then 0xBBBB to lane 2.
  - lane_full[2]=1 and in_ready=0 while in_sel=2; in_ready=1 for in_sel=0.
  - Raise out_ready[2]: 0xAAAA then 0xBBBB drain in order.
- Broadcast: in_bcast=1, in_data=0x1234, all lanes empty.
  - All four out_data*=0x1234 and out_valid=4'hF next cycle; xfer_cnt increments by 1.
  - Then fill lane 1 only: broadcast in_ready=0 until lane 1 drains one entry.
- Simultaneous push/pop on a lane with occupancy 1 (head 0x0011), push 0x0022 with out_ready=1.
  - Occupancy stays 1 and head becomes 0x0022. Repeat 8 times to exercise pointer wrap with no data loss.
- Counter wrap: perform 65536 accepted transfers.
  - xfer_cnt returns to 0x0000 after 0xFFFF.
- Reset mid-operation: lanes 0 and 3 full, assert rst_n=0 asynchronously between edges.
  - out_valid=0, lane_full=0, xfer_cnt=0 and in_ready=1 immediately, before the next edge.
